mem_arbiter: RTL and testbench

Single-port memory arbiter between the two L1 caches and the asynchronous main memory. It accepts three line-granular requesters: I-cache read (fill), D-cache read (fill) and D-cache write (dirty-line writeback). It serialises them onto one enable/ack memory handshake and returns read lines and completion pulses to the winner. It sits downstream of Icache/Dcache and directly upstream of memory_async.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter_grant_select.sv | 23 ++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the L1-to-memory arbiter: default widths, requester ids, states.
package mem_arbiter_pkg;

  localparam int unsigned DefAddrW       = 32;
  localparam int unsigned DefLineW       = 128;
  localparam int unsigned DefStarveLimit = 4;
  localparam int unsigned DefCntW        = 3;

  // Requester ids double as bit positions in the request/grant vectors.
  localparam int unsigned NumReq = 3;
  localparam int unsigned IdxIc  = 0;
  localparam int unsigned IdxDcr = 1;
  localparam int unsigned IdxDcw = 2;

  localparam logic MemRead  = 1'b0;
  localparam logic MemWrite = 1'b1;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbBusy = 2'd1,
    ArbDone = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/ack lines and the memory enable/ack handshake seen by the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned AddrW = mem_arbiter_pkg::DefAddrW,
  parameter int unsigned LineW = mem_arbiter_pkg::DefLineW
);

  logic             ic_read_req;
  logic [AddrW-1:0] ic_read_addr;
  logic             ic_read_ack;
  logic [LineW-1:0] ic_read_data;

  logic             dc_read_req;
  logic [AddrW-1:0] dc_read_addr;
  logic             dc_read_ack;
  logic [LineW-1:0] dc_read_data;

  logic             dc_write_req;
  logic [AddrW-1:0] dc_write_addr;
  logic [LineW-1:0] dc_write_data;
  logic             dc_write_ack;

  logic             mem_enable;
  logic             mem_rw;
  logic             mem_ack;
  logic [AddrW-1:0] mem_addr;
  logic [LineW-1:0] mem_data_in;
  logic [LineW-1:0] mem_data_out;

  // Arbiter view.
  modport master (
    input  ic_read_req, ic_read_addr, dc_read_req, dc_read_addr,
           dc_write_req, dc_write_addr, dc_write_data, mem_ack, mem_data_in,
    output ic_read_ack, ic_read_data, dc_read_ack, dc_read_data, dc_write_ack,
           mem_enable, mem_rw, mem_addr, mem_data_out
  );

  // Caches plus memory view.
  modport slave (
    output ic_read_req, ic_read_addr, dc_read_req, dc_read_addr,
           dc_write_req, dc_write_addr, dc_write_data, mem_ack, mem_data_in,
    input  ic_read_ack, ic_read_data, dc_read_ack, dc_read_data, dc_write_ack,
           mem_enable, mem_rw, mem_addr, mem_data_out
  );

endinterface

// File: rtl/mem_arbiter_grant_select.sv
// Fixed priority (writeback > D fill > I fill) with an I-fill starvation override.
module mem_arbiter_grant_select
  import mem_arbiter_pkg::*;
(
  input  logic [NumReq-1:0] req_i,
  input  logic              starve_i,
  output logic [NumReq-1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (req_i[IdxIc] && starve_i) begin
      gnt_o[IdxIc] = 1'b1;
    end else if (req_i[IdxDcw]) begin
      gnt_o[IdxDcw] = 1'b1;
    end else if (req_i[IdxDcr]) begin
      gnt_o[IdxDcr] = 1'b1;
    end else if (req_i[IdxIc]) begin
      gnt_o[IdxIc] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-fill, D-fill and D-writeback line requests onto one enable/ack memory handshake.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AddrW       = DefAddrW,
  parameter int unsigned LineW       = DefLineW,
  parameter int unsigned StarveLimit = DefStarveLimit,
  parameter int unsigned CntW        = DefCntW
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.master bus
);

  localparam logic [CntW-1:0] CntMax = CntW'(StarveLimit);

  arb_state_e        state_q, state_d;
  logic [NumReq-1:0] req, gnt, gnt_q, gnt_d;
  logic [CntW-1:0]   starve_cnt_q, starve_cnt_d;
  logic              starve;

  logic              mem_enable_q, mem_enable_d;
  logic              mem_rw_q, mem_rw_d;
  logic [AddrW-1:0]  mem_addr_q, mem_addr_d;
  logic [LineW-1:0]  mem_data_out_q, mem_data_out_d;
  logic [LineW-1:0]  ic_data_q, ic_data_d;
  logic [LineW-1:0]  dcr_data_q, dcr_data_d;
  logic              ic_ack_q, ic_ack_d;
  logic              dcr_ack_q, dcr_ack_d;
  logic              dcw_ack_q, dcw_ack_d;

  assign req[IdxIc]  = bus.ic_read_req;
  assign req[IdxDcr] = bus.dc_read_req;
  assign req[IdxDcw] = bus.dc_write_req;
  assign starve      = bus.ic_read_req && (starve_cnt_q == CntMax);

  mem_arbiter_grant_select u_grant_select (
    .req_i    (req),
    .starve_i (starve),
    .gnt_o    (gnt)
  );

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    starve_cnt_d   = starve_cnt_q;
    mem_enable_d   = mem_enable_q;
    mem_rw_d       = mem_rw_q;
    mem_addr_d     = mem_addr_q;
    mem_data_out_d = mem_data_out_q;
    ic_data_d      = ic_data_q;
    dcr_data_d     = dcr_data_q;
    ic_ack_d       = 1'b0;
    dcr_ack_d      = 1'b0;
    dcw_ack_d      = 1'b0;

    unique case (state_q)
      ArbIdle: begin
        if (|req) begin
          gnt_d        = gnt;
          mem_enable_d = 1'b1;
          state_d      = ArbBusy;
          unique case (1'b1)
            gnt[IdxIc]: begin
              mem_addr_d = bus.ic_read_addr;
              mem_rw_d   = MemRead;
            end
            gnt[IdxDcr]: begin
              mem_addr_d = bus.dc_read_addr;
              mem_rw_d   = MemRead;
            end
            gnt[IdxDcw]: begin
              mem_addr_d     = bus.dc_write_addr;
              mem_rw_d       = MemWrite;
              mem_data_out_d = bus.dc_write_data;
            end
            default: ;
          endcase
          // Count D grants that overtook a waiting I fill; an I grant or idle I side clears it.
          if (gnt[IdxIc] || !bus.ic_read_req) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q != CntMax) begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
          end
        end else begin
          mem_enable_d = 1'b0;
          if (!bus.ic_read_req) starve_cnt_d = '0;
        end
      end
      ArbBusy: begin
        if (bus.mem_ack) begin
          mem_enable_d = 1'b0;
          state_d      = ArbDone;
          unique case (1'b1)
            gnt_q[IdxIc]: begin
              ic_data_d = bus.mem_data_in;
              ic_ack_d  = 1'b1;
            end
            gnt_q[IdxDcr]: begin
              dcr_data_d = bus.mem_data_in;
              dcr_ack_d  = 1'b1;
            end
            gnt_q[IdxDcw]: dcw_ack_d = 1'b1;
            default: ;
          endcase
        end
      end
      ArbDone: begin
        if (!bus.mem_ack) state_d = ArbIdle;
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ArbIdle;
      gnt_q          <= '0;
      starve_cnt_q   <= '0;
      mem_enable_q   <= 1'b0;
      mem_rw_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_out_q <= '0;
      ic_data_q      <= '0;
      dcr_data_q     <= '0;
      ic_ack_q       <= 1'b0;
      dcr_ack_q      <= 1'b0;
      dcw_ack_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      starve_cnt_q   <= starve_cnt_d;
      mem_enable_q   <= mem_enable_d;
      mem_rw_q       <= mem_rw_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_out_q <= mem_data_out_d;
      ic_data_q      <= ic_data_d;
      dcr_data_q     <= dcr_data_d;
      ic_ack_q       <= ic_ack_d;
      dcr_ack_q      <= dcr_ack_d;
      dcw_ack_q      <= dcw_ack_d;
    end
  end

  assign bus.mem_enable   = mem_enable_q;
  assign bus.mem_rw       = mem_rw_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data_out = mem_data_out_q;
  assign bus.ic_read_ack  = ic_ack_q;
  assign bus.ic_read_data = ic_data_q;
  assign bus.dc_read_ack  = dcr_ack_q;
  assign bus.dc_read_data = dcr_data_q;
  assign bus.dc_write_ack = dcw_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester tasks, a reactive memory and a priority model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned AW = DefAddrW;
  localparam int unsigned LW = DefLineW;
  localparam int          SL = DefStarveLimit;
  localparam int          IC  = 0;
  localparam int          DCR = 1;
  localparam int          DCW = 2;

  typedef struct {
    int          who;
    logic [LW-1:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AddrW(AW), .LineW(LW)) bus ();

  mem_arbiter #(
    .AddrW       (AW),
    .LineW       (LW),
    .StarveLimit (SL),
    .CntW        (DefCntW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            cur_who = -1;
  int            last_gap = 0;
  bit            rst_at_edge = 1'b0;
  int            lat_min, lat_max, hold_min, hold_max;
  bit            use_fixed;
  logic [LW-1:0] fixed_data = {4{32'hDEADBEEF}};
  exp_t          exp_q[$];
  int            grant_log[$];

  always @(posedge clk) cyc++;

  function automatic void check(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void check_i(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void check_log(string name, int n, int e0, int e1, int e2, int e3, int e4);
    int e[5];
    e = '{e0, e1, e2, e3, e4};
    check_i({name, "_count_ok"}, int'(grant_log.size() >= n), 1);
    for (int i = 0; i < n && i < grant_log.size(); i++) check_i(name, grant_log[i], e[i]);
  endfunction

  function automatic bit ack_of(int who);
    if (who == IC) return bus.ic_read_ack;
    if (who == DCR) return bus.dc_read_ack;
    return bus.dc_write_ack;
  endfunction

  task automatic do_req(input int who, input logic [AW-1:0] addr, input logic [LW-1:0] wdata);
    int t;
    @(negedge clk);
    if (who == IC) begin
      bus.ic_read_req = 1'b1; bus.ic_read_addr = addr;
    end else if (who == DCR) begin
      bus.dc_read_req = 1'b1; bus.dc_read_addr = addr;
    end else begin
      bus.dc_write_req = 1'b1; bus.dc_write_addr = addr; bus.dc_write_data = wdata;
    end
    t = 0;
    while (!ack_of(who) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: requester %0d got no ack after %0d cycles, required one", who, t);
    end
    if (who == IC) bus.ic_read_req = 1'b0;
    else if (who == DCR) bus.dc_read_req = 1'b0;
    else bus.dc_write_req = 1'b0;
  endtask

  // Memory: acks after a random latency, holds ack until enable drops plus an optional tail.
  initial begin : memory
    int            lat, hold, t;
    bit            alive;
    logic [LW-1:0] rd;
    bus.mem_ack     = 1'b0;
    bus.mem_data_in = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_enable === 1'b1 && !bus.mem_ack) begin
        lat   = $urandom_range(lat_max, lat_min);
        alive = 1'b1;
        for (int i = 1; i < lat && alive; i++) begin
          @(negedge clk);
          if (bus.mem_enable !== 1'b1) alive = 1'b0;
        end
        if (alive) begin
          rd = use_fixed ? fixed_data : {$urandom, $urandom, $urandom, $urandom};
          bus.mem_data_in = rd;
          bus.mem_ack     = 1'b1;
          exp_q.push_back('{who: cur_who, data: rd, cyc: cyc});
          t = 0;
          while (bus.mem_enable === 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
          end
          hold = $urandom_range(hold_max, hold_min);
          repeat (hold) @(negedge clk);
          bus.mem_ack     = 1'b0;
          bus.mem_data_in = {$urandom, $urandom, $urandom, $urandom};
        end
      end
    end
  end

  // Reference model: who must win each grant, from the priority and starvation rules.
  initial begin : model
    bit            en_prev, seen;
    int            gap, starve, w;
    logic          s_ic, s_dcr, s_dcw, s_ack, s_rst;
    logic [AW-1:0] a_ic, a_dcr, a_dcw;
    logic [LW-1:0] d_dcw, h_data;
    logic [AW-1:0] h_addr;
    logic          h_rw;
    en_prev = 1'b0; seen = 1'b0; gap = 0; starve = 0;
    h_addr = '0; h_rw = 1'b0; h_data = '0;
    forever begin
      @(posedge clk);
      s_rst = reset; s_ack = bus.mem_ack;
      s_ic = bus.ic_read_req; s_dcr = bus.dc_read_req; s_dcw = bus.dc_write_req;
      a_ic = bus.ic_read_addr; a_dcr = bus.dc_read_addr; a_dcw = bus.dc_write_addr;
      d_dcw = bus.dc_write_data;
      rst_at_edge = s_rst;
      #1;
      if (s_rst) begin
        starve = 0; seen = 1'b0; gap = 0;
      end else if (bus.mem_enable && !en_prev) begin
        if (s_ic && starve == SL) w = IC;
        else if (s_dcw) w = DCW;
        else if (s_dcr) w = DCR;
        else if (s_ic) w = IC;
        else w = -1;
        check_i("grant_has_request", int'(w >= 0), 1);
        check_i("grant_mem_ack_low", int'(s_ack), 0);
        if (seen) check_i("grant_idle_gap_ge2", int'(gap >= 2), 1);
        last_gap = gap;
        if (w == IC) begin
          check("grant_addr_ic", LW'(bus.mem_addr), LW'(a_ic));
          check_i("grant_rw_ic", int'(bus.mem_rw), 0);
          starve = 0;
        end else if (w == DCR) begin
          check("grant_addr_dcr", LW'(bus.mem_addr), LW'(a_dcr));
          check_i("grant_rw_dcr", int'(bus.mem_rw), 0);
        end else if (w == DCW) begin
          check("grant_addr_dcw", LW'(bus.mem_addr), LW'(a_dcw));
          check_i("grant_rw_dcw", int'(bus.mem_rw), 1);
          check("grant_wdata", bus.mem_data_out, d_dcw);
        end
        if (w != IC && s_ic && starve < SL) starve++;
        cur_who = w;
        grant_log.push_back(w);
        h_addr = bus.mem_addr; h_rw = bus.mem_rw; h_data = bus.mem_data_out;
        gap = 0;
        seen = 1'b1;
      end else if (bus.mem_enable) begin
        check_i("busy_outputs_stable",
                int'(bus.mem_addr === h_addr && bus.mem_rw === h_rw && bus.mem_data_out === h_data), 1);
      end else begin
        gap++;
      end
      en_prev = bus.mem_enable;
    end
  end

  // Ack monitor: pops the scoreboard whenever any requester ack is presented.
  initial begin : ack_mon
    logic [LW-1:0] exp_ic, exp_dcr;
    int            n, who;
    exp_t          e;
    exp_ic = '0; exp_dcr = '0;
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        exp_ic = '0; exp_dcr = '0;
        exp_q.delete();
      end
      n = int'(bus.ic_read_ack) + int'(bus.dc_read_ack) + int'(bus.dc_write_ack);
      if (n > 1) begin
        check_i("one_ack_per_cycle", n, 1);
      end else if (n == 1) begin
        who = bus.ic_read_ack ? IC : (bus.dc_read_ack ? DCR : DCW);
        if (exp_q.size() == 0) begin
          check_i("unexpected_ack_from", who, -1);
        end else begin
          e = exp_q.pop_front();
          check_i("ack_requester", who, e.who);
          check_i("ack_cycle_after_mem_ack", cyc, e.cyc + 1);
          if (who == IC) exp_ic = e.data;
          else if (who == DCR) exp_dcr = e.data;
        end
      end
      check("ic_read_data", bus.ic_read_data, exp_ic);
      check("dc_read_data", bus.dc_read_data, exp_dcr);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached before end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int t;
    reset = 1'b1;
    bus.ic_read_req = 1'b0; bus.dc_read_req = 1'b0; bus.dc_write_req = 1'b0;
    bus.ic_read_addr = '0; bus.dc_read_addr = '0; bus.dc_write_addr = '0;
    bus.dc_write_data = '0;
    lat_min = 1; lat_max = 6; hold_min = 0; hold_max = 0; use_fixed = 1'b0;
    repeat (3) @(negedge clk);
    check_i("rst_mem_enable", int'(bus.mem_enable), 0);
    check_i("rst_mem_rw", int'(bus.mem_rw), 0);
    check("rst_mem_addr", LW'(bus.mem_addr), '0);
    check("rst_mem_data_out", bus.mem_data_out, '0);
    check_i("rst_acks", int'({bus.ic_read_ack, bus.dc_read_ack, bus.dc_write_ack}), 0);
    reset = 1'b0;

    // Single I fill, memory acks 5 cycles after enable.
    lat_min = 5; lat_max = 5; use_fixed = 1'b1;
    grant_log.delete();
    do_req(IC, 32'h40, '0);
    repeat (2) @(negedge clk);
    check("ic_fill_data_held", bus.ic_read_data, fixed_data);
    check_log("ic_fill_order", 1, IC, 0, 0, 0, 0);

    // Writeback and fill raised together: writeback first.
    lat_min = 1; lat_max = 6; use_fixed = 1'b0;
    grant_log.delete();
    fork
      do_req(DCW, 32'h80, {4{32'hA5A5A5A5}});
      do_req(DCR, 32'h100, '0);
    join
    check_log("wb_then_fill_order", 2, DCW, DCR, 0, 0, 0);

    // All three at once.
    grant_log.delete();
    fork
      do_req(DCW, 32'h180, {$urandom, $urandom, $urandom, $urandom});
      do_req(DCR, 32'h1c0, '0);
      do_req(IC, 32'h200, '0);
    join
    check_log("all_three_order", 3, DCW, DCR, IC, 0, 0);

    // Starvation: continuous D fills while an I fill waits.
    grant_log.delete();
    fork
      do_req(IC, 32'h240, '0);
      for (int k = 0; k < 6; k++) do_req(DCR, AW'(32'h400 + k * 64), '0);
    join
    check_log("starve_order", 5, DCR, DCR, DCR, DCR, IC);

    // Slow ack release; normal priority again shows the starvation count cleared.
    hold_min = 3; hold_max = 3;
    grant_log.delete();
    fork
      do_req(IC, 32'h2c0, '0);
      do_req(DCR, 32'h300, '0);
    join
    check_log("post_starve_order", 2, DCR, IC, 0, 0, 0);
    check_i("slow_release_gap_ge5", int'(last_gap >= 5), 1);
    hold_min = 0; hold_max = 0;

    // Reset while a fill is outstanding.
    lat_min = 20; lat_max = 20;
    repeat (2) @(negedge clk);
    bus.ic_read_req = 1'b1; bus.ic_read_addr = 32'h340;
    t = 0;
    while (bus.mem_enable !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_i("abort_enable_seen", int'(bus.mem_enable), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_i("abort_mem_enable", int'(bus.mem_enable), 0);
    check_i("abort_mem_rw", int'(bus.mem_rw), 0);
    check("abort_mem_addr", LW'(bus.mem_addr), '0);
    check("abort_mem_data_out", bus.mem_data_out, '0);
    check("abort_ic_data", bus.ic_read_data, '0);
    check("abort_dc_data", bus.dc_read_data, '0);
    check_i("abort_acks", int'({bus.ic_read_ack, bus.dc_read_ack, bus.dc_write_ack}), 0);
    reset = 1'b0;
    bus.ic_read_req = 1'b0;
    repeat (30) @(negedge clk);
    lat_min = 1; lat_max = 6;
    grant_log.delete();
    do_req(IC, 32'h340, '0);
    check_log("reissue_order", 1, IC, 0, 0, 0, 0);

    // Randomised traffic from all three requesters.
    hold_min = 0; hold_max = 2;
    fork
      for (int k = 0; k < 15; k++) begin
        repeat ($urandom_range(3, 0)) @(negedge clk);
        do_req(IC, AW'($urandom), '0);
      end
      for (int k = 0; k < 15; k++) begin
        repeat ($urandom_range(3, 0)) @(negedge clk);
        do_req(DCR, AW'($urandom), '0);
      end
      for (int k = 0; k < 15; k++) begin
        repeat ($urandom_range(3, 0)) @(negedge clk);
        do_req(DCW, AW'($urandom), {$urandom, $urandom, $urandom, $urandom});
      end
    join
    repeat (10) @(negedge clk);
    check_i("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
